// File: rtl/div.sv
// Sequential restoring divider, 16-bit dividend / 8-bit divisor, 16 iterations.
// Trial subtraction uses an external shared adder. Optional macro: DIV_EARLY_EXIT_EN.
//
// state | meaning
// IDLE  | waiting for start; results held, adder operands forced to 0
// WORK  | one quotient bit resolved per clock, cnt counts down to 0
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        dbz,
  output logic        busy,
  output logic [15:0] sum_in_a,
  output logic [15:0] sum_in_b,
  input  logic [15:0] sum_out
);

  typedef enum logic {IDLE, WORK} state_t;

  state_t      state, state_nxt;
  logic [15:0] dvd;
  logic [15:0] q_sh;
  logic [7:0]  dvs;
  logic [8:0]  r;
  logic [8:0]  t;
  logic [8:0]  r_nxt;
  logic [4:0]  cnt;
  logic        q_bit;
  logic        early;
  logic        unused_sum;

  // Non-negative trial results never exceed 9 bits; only the sign bit decides.
  assign unused_sum = ^sum_out[14:9];
  assign busy       = (state == WORK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sum_in_a  = 16'd0;
    sum_in_b  = 16'd0;
    t         = {r[7:0], dvd[15]};
    r_nxt     = t;
    q_bit     = 1'b0;
    early     = 1'b0;
`ifdef DIV_EARLY_EXIT_EN
    early     = (a_i < {8'd0, b_i});
`endif
    case (state)
      IDLE: begin
        if (start && (b_i != 8'd0) && !early) state_nxt = WORK;
      end
      WORK: begin
        sum_in_a = {7'd0, t};
        sum_in_b = ~{8'd0, dvs} + 16'd1;
        if (!sum_out[15]) begin
          r_nxt = sum_out[8:0];
          q_bit = 1'b1;
        end
        if (cnt == 5'd1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd       <= 16'd0;
      dvs       <= 8'd0;
      r         <= 9'd0;
      q_sh      <= 16'd0;
      cnt       <= 5'd0;
      quotient  <= 16'd0;
      remainder <= 8'd0;
      dbz       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvd  <= a_i;
            dvs  <= b_i;
            r    <= 9'd0;
            q_sh <= 16'd0;
            cnt  <= 5'd16;
            if (b_i == 8'd0) begin
              quotient  <= 16'hFFFF;
              remainder <= 8'd0;
              dbz       <= 1'b1;
            end else if (early) begin
              quotient  <= 16'd0;
              remainder <= a_i[7:0];
              dbz       <= 1'b0;
            end else begin
              dbz <= 1'b0;
            end
          end
        end
        WORK: begin
          r    <= r_nxt;
          q_sh <= {q_sh[14:0], q_bit};
          dvd  <= {dvd[14:0], 1'b0};
          cnt  <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            quotient  <= {q_sh[14:0], q_bit};
            remainder <= r_nxt[7:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
